i2s_stream_tx: RTL and testbench
================================

Name: i2s_stream_tx

Overview:
Parametrised successor to the mono I2S transmitter: stereo, sample-width/slot-width generic, with an internal frame FIFO and valid/ready input handshake. BCLK and LRCLK are generated internally from the single system clock by a clock-enable divider, so no PLL BCLK output is needed. Selectable I2S or left-justified format, mute, and a sticky underrun flag. Sits between the waveform generator/DSP chain and the codec DAC pins.

Parameters:
DATA_WIDTH, 24, sample bits per channel (two's complement, MSB first)
SLOT_WIDTH, 32, BCLK cycles per channel slot; must be >= DATA_WIDTH+1
BCLK_DIV, 4, clk cycles per BCLK period; even, >= 2
FIFO_DEPTH, 8, stereo frames buffered; power of 2, >= 2

Ports:
clk  in  1  system clock (codec MCLK domain)
rst_n  in  1  reset, synchronous, active-low
i_left  in  DATA_WIDTH  left sample
i_right  in  DATA_WIDTH  right sample
i_valid  in  1  frame valid
o_ready  out  1  FIFO can accept; push = i_valid & o_ready
i_mode  in  1  0 = I2S (MSB one BCLK after LRCLK edge), 1 = left-justified
i_mute  in  1  force serial data to zero
i_clr_underrun  in  1  clears o_underrun
o_bclk  out  1  bit clock
o_lrclk  out  1  0 = left slot, 1 = right slot
o_dacdat  out  1  serial data
o_frame_tick  out  1  one-clk pulse at each frame start
o_underrun  out  1  sticky underrun flag
o_level  out  $clog2(FIFO_DEPTH)+1  frames in FIFO

Behaviour:
- Reset (rst_n=0 at a clk edge): div_cnt=0, bit_cnt=2*SLOT_WIDTH-1, FIFO emptied, armed=0. Outputs: o_bclk=0, o_lrclk=1, o_dacdat=0, o_frame_tick=0, o_underrun=0, o_level=0. o_ready=1 (combinational: o_level != FIFO_DEPTH). Reset mid-frame takes effect at the next edge and aborts the frame.
- Divider: div_cnt counts 0..BCLK_DIV-1 and wraps. o_bclk is registered: 0 while div_cnt < BCLK_DIV/2, 1 otherwise.
- Falling-edge event F: the cycle with div_cnt==BCLK_DIV-1. On F, bit_cnt increments and wraps from 2*SLOT_WIDTH-1 to 0, and o_lrclk and o_dacdat update. The receiver samples on the BCLK rise.
- LRCLK: o_lrclk = (bit_cnt >= SLOT_WIDTH), registered on F.
- Frame start: F with bit_cnt wrapping to 0; the first occurs BCLK_DIV clk cycles after reset release. On frame start:
  - i_mode is latched; mid-frame mode changes apply from the next frame.
  - If FIFO non-empty: pop one frame into the left/right shift registers and set armed=1.
  - If FIFO empty: load zeros, and set o_underrun if armed.
  - o_frame_tick=1 for that clk only.
- Data mapping: within a slot, position p = bit_cnt mod SLOT_WIDTH and offset d = 0 (LJ) or 1 (I2S).
  - For d <= p < d+DATA_WIDTH: o_dacdat = sample[DATA_WIDTH-1-(p-d)].
  - Otherwise o_dacdat = 0.
  - i_mute=1 forces o_dacdat=0; the FIFO still pops.
- FIFO:
  - Push on i_valid & o_ready; no push when full.
  - Simultaneous push and pop leaves o_level unchanged, data order preserved.
  - A push into an empty FIFO in the same cycle as a pop is not bypassed; the pop sees empty and treats it as underrun.
  - o_level is registered and updates the cycle after the push/pop.
- Underrun flag: sticky. i_clr_underrun clears it; a set and a clear in the same cycle resolve as set. No underrun is flagged before the first successful pop after reset.
- Arithmetic: counters are unsigned. bit_cnt width is $clog2(2*SLOT_WIDTH). Frame length = 2*SLOT_WIDTH*BCLK_DIV clk cycles.

Test Plan:
(defaults DATA_WIDTH=24, SLOT_WIDTH=32, BCLK_DIV=4, FIFO_DEPTH=4)
- LJ: push L=0xA5A5A5, R=0x5A5A5A -> next frame, o_dacdat over slot bits 0..23 = A5A5A5 MSB first with o_lrclk=0, bits 24..31 = 0, then 5A5A5A with o_lrclk=1. BCLK period is 4 clk; frame is 256 clk.
- I2S: push L=0x800001 -> o_dacdat=0 at slot bit 0, 1 at bit 1, 0 over bits 2..23, 1 at bit 24, 0 over bits 25..31.
- Backpressure: hold i_valid=1 with FIFO draining stalled before first frame start -> o_level 1,2,3,4; o_ready=0 at 4; 5th frame accepted only the cycle after a pop.
- Underrun: after reset wait 3 frames with no push -> o_underrun stays 0. Push 1 frame and wait 2 frames -> second frame all zeros and o_underrun=1. Assert i_clr_underrun and a new underrun together -> o_underrun stays 1; clear alone -> 0.
- Mute: i_mute=1 with 2 frames queued -> o_dacdat=0 throughout, o_level 2->1->0, o_frame_tick every 256 clk.
- Reset mid-frame at bit_cnt=40 -> next cycle o_bclk=0, o_lrclk=1, o_dacdat=0, o_level=0, o_underrun=0; first o_frame_tick at cycle 4 after release.

Source files
------------

// File: rtl/i2s_stream_if.sv
// Stereo sample stream with valid/ready handshake feeding the I2S transmitter.
interface i2s_stream_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
    logic                  valid;
    logic                  ready;

    modport master (output left, output right, output valid, input ready);
    modport slave  (input left, input right, input valid, output ready);
endinterface

// File: rtl/i2s_stream_tx.sv
// Stereo I2S / left-justified serialiser with frame FIFO, internal BCLK/LRCLK
// generation from the system clock, mute and sticky underrun reporting.
module i2s_stream_tx #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    i2s_stream_if.slave                 s_in,
    input  logic                        i_mode,
    input  logic                        i_mute,
    input  logic                        i_clr_underrun,
    output logic                        o_bclk,
    output logic                        o_lrclk,
    output logic                        o_dacdat,
    output logic                        o_frame_tick,
    output logic                        o_underrun,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W      = PTR_W + 1;

    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_next;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_next;
    logic                  fall;
    logic                  frame_start;

    logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    logic [DATA_WIDTH-1:0] sample_l;
    logic [DATA_WIDTH-1:0] sample_r;
    logic                  mode_q;
    logic                  armed;
    logic                  underrun_set;

    logic [DATA_WIDTH-1:0] cur_l;
    logic [DATA_WIDTH-1:0] cur_r;
    logic                  cur_mode;
    logic                  slot_right;
    logic                  data_bit;

    assign fall        = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign div_next    = fall ? '0 : div_cnt + 1'b1;
    assign bit_next    = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    assign frame_start = fall && (bit_cnt == BIT_W'(FRAME_BITS - 1));

    // The registered level decides emptiness, so a same-cycle push is never bypassed.
    assign fifo_empty   = (o_level == '0);
    assign s_in.ready   = (o_level != LVL_W'(FIFO_DEPTH));
    assign push         = s_in.valid && s_in.ready;
    assign pop          = frame_start && !fifo_empty;
    assign underrun_set = frame_start && fifo_empty && armed;

    // Serial bit for the slot position being entered on this falling edge.
    always_comb begin
        logic [31:0]           pos;
        logic [31:0]           p;
        logic [31:0]           d;
        logic [31:0]           idx;
        logic [DATA_WIDTH-1:0] sample;
        logic [DATA_WIDTH-1:0] shifted;

        cur_l      = sample_l;
        cur_r      = sample_r;
        cur_mode   = mode_q;
        if (frame_start) begin
            cur_l    = pop ? mem_l[rd_ptr] : '0;
            cur_r    = pop ? mem_r[rd_ptr] : '0;
            cur_mode = i_mode;
        end

        pos        = 32'(bit_next);
        slot_right = (pos >= SLOT_WIDTH);
        p          = slot_right ? pos - SLOT_WIDTH : pos;
        d          = cur_mode ? 32'd0 : 32'd1;
        idx        = p - d;
        sample     = slot_right ? cur_r : cur_l;
        shifted    = sample << idx;
        data_bit   = 1'b0;
        if ((p >= d) && (idx < DATA_WIDTH)) begin
            data_bit = shifted[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            bit_cnt      <= BIT_W'(FRAME_BITS - 1);
            o_bclk       <= 1'b0;
            o_lrclk      <= 1'b1;
            o_dacdat     <= 1'b0;
            o_frame_tick <= 1'b0;
            o_underrun   <= 1'b0;
            o_level      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sample_l     <= '0;
            sample_r     <= '0;
            mode_q       <= 1'b0;
            armed        <= 1'b0;
        end else begin
            div_cnt      <= div_next;
            o_bclk       <= (32'(div_next) >= (BCLK_DIV / 2));
            o_frame_tick <= frame_start;

            if (fall) begin
                bit_cnt  <= bit_next;
                o_lrclk  <= slot_right;
                o_dacdat <= data_bit && !i_mute;
            end

            if (frame_start) begin
                sample_l <= cur_l;
                sample_r <= cur_r;
                mode_q   <= i_mode;
            end
            if (pop) begin
                armed <= 1'b1;
            end

            // A set outranks a clear arriving in the same cycle.
            if (underrun_set) begin
                o_underrun <= 1'b1;
            end else if (i_clr_underrun) begin
                o_underrun <= 1'b0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                o_level <= o_level + 1'b1;
            end else if (pop && !push) begin
                o_level <= o_level - 1'b1;
            end
        end
    end

    // Frame storage carries no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= s_in.left;
            mem_r[wr_ptr] <= s_in.right;
        end
    end

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Directed self-checking bench for i2s_stream_tx: formats, backpressure,
// underrun, mute and mid-frame reset.
module tb_i2s_stream_tx;

    localparam int unsigned DW = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_mode = 1'b1;
    logic       i_mute = 1'b0;
    logic       i_clr_underrun = 1'b0;
    logic       o_bclk;
    logic       o_lrclk;
    logic       o_dacdat;
    logic       o_frame_tick;
    logic       o_underrun;
    logic [2:0] o_level;

    int checks = 0;
    int passed = 0;

    i2s_stream_if #(.DATA_WIDTH(DW)) s_if ();

    i2s_stream_tx #(
        .DATA_WIDTH(DW),
        .SLOT_WIDTH(32),
        .BCLK_DIV  (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_in          (s_if),
        .i_mode        (i_mode),
        .i_mute        (i_mute),
        .i_clr_underrun(i_clr_underrun),
        .o_bclk        (o_bclk),
        .o_lrclk       (o_lrclk),
        .o_dacdat      (o_dacdat),
        .o_frame_tick  (o_frame_tick),
        .o_underrun    (o_underrun),
        .o_level       (o_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench 1 time unit after the last reset edge, with rst_n released.
    task automatic do_reset();
        rst_n          = 1'b0;
        s_if.valid     = 1'b0;
        s_if.left      = '0;
        s_if.right     = '0;
        i_clr_underrun = 1'b0;
        i_mute         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        s_if.left  = l;
        s_if.right = r;
        s_if.valid = 1'b1;
        tick();
        s_if.valid = 1'b0;
    endtask

    // Called 1 unit after a frame-start edge; returns at the next frame start + 1.
    task automatic capture_frame(output logic [63:0] dat, output logic [63:0] lr,
                                 output logic [3:0] bclk_pat, output int tick_cnt);
        dat = '0;
        lr = '0;
        bclk_pat = '0;
        tick_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (i % 4 == 0) begin
                dat = {dat[62:0], o_dacdat};
                lr  = {lr[62:0], o_lrclk};
            end
            if (i < 4) bclk_pat = {bclk_pat[2:0], o_bclk};
            if (o_frame_tick) tick_cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        s_if.valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({o_bclk, o_lrclk, o_dacdat, o_frame_tick, o_underrun} !== 5'b01000) begin
            $display("FAIL reset_outputs: got %b expected 01000",
                     {o_bclk, o_lrclk, o_dacdat, o_frame_tick, o_underrun});
        end else passed++;
        checks++;
        if (o_level !== 3'd0 || s_if.ready !== 1'b1) begin
            $display("FAIL reset_level_ready: got level %0d ready %b expected 0 1", o_level, s_if.ready);
        end else passed++;
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (o_frame_tick === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 4) $display("FAIL reset_first_tick: got cycle %0d expected 4", n);
        else passed++;
    endtask

    task automatic test_lj();
        logic [63:0] dat;
        logic [63:0] lr;
        logic [3:0]  bp;
        int          tc;
        i_mode = 1'b1;
        do_reset();
        push_frame(24'hA5A5A5, 24'h5A5A5A);
        ticks(3);
        capture_frame(dat, lr, bp, tc);
        checks++;
        if (dat !== 64'hA5A5A500_5A5A5A00) $display("FAIL lj_data: got %h expected a5a5a5005a5a5a00", dat);
        else passed++;
        checks++;
        if (lr !== 64'h00000000_FFFFFFFF) $display("FAIL lj_lrclk: got %h expected 00000000ffffffff", lr);
        else passed++;
        checks++;
        if (bp !== 4'b0011) $display("FAIL lj_bclk: got %b expected 0011", bp);
        else passed++;
        checks++;
        if (tc != 1 || o_frame_tick !== 1'b1) begin
            $display("FAIL lj_frame_len: got ticks %0d next_tick %b expected 1 1", tc, o_frame_tick);
        end else passed++;
    endtask

    task automatic test_i2s();
        logic [63:0] dat;
        logic [63:0] lr;
        logic [3:0]  bp;
        int          tc;
        i_mode = 1'b0;
        do_reset();
        push_frame(24'h800001, 24'h000001);
        ticks(3);
        capture_frame(dat, lr, bp, tc);
        checks++;
        if (dat !== 64'h40000080_00000080) $display("FAIL i2s_data: got %h expected 4000008000000080", dat);
        else passed++;
        i_mode = 1'b1;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] lv [5];
        logic [63:0]   dat;
        logic [63:0]   lr;
        logic [3:0]    bp;
        int            tc;
        lv[0] = 24'h123456; lv[1] = 24'h234567; lv[2] = 24'h345678;
        lv[3] = 24'h456789; lv[4] = 24'h56789A;
        i_mode = 1'b1;
        do_reset();
        ticks(4);
        s_if.valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_if.left  = lv[i];
            s_if.right = ~lv[i];
            if (i < 4) begin
                tick();
                checks++;
                if (o_level !== 3'(i + 1)) $display("FAIL bp_fill%0d: got %0d expected %0d", i, o_level, i + 1);
                else passed++;
            end
        end
        checks++;
        if (s_if.ready !== 1'b0) $display("FAIL bp_ready_full: got %b expected 0", s_if.ready);
        else passed++;
        ticks(251);
        checks++;
        if (o_level !== 3'd4 || s_if.ready !== 1'b0) begin
            $display("FAIL bp_stall: got level %0d ready %b expected 4 0", o_level, s_if.ready);
        end else passed++;
        tick();
        checks++;
        if (o_level !== 3'd3 || s_if.ready !== 1'b1 || o_frame_tick !== 1'b1) begin
            $display("FAIL bp_after_pop: got level %0d ready %b tick %b expected 3 1 1",
                     o_level, s_if.ready, o_frame_tick);
        end else passed++;
        tick();
        s_if.valid = 1'b0;
        checks++;
        if (o_level !== 3'd4) $display("FAIL bp_fifth_push: got %0d expected 4", o_level);
        else passed++;
        ticks(255);
        for (int f = 1; f < 5; f++) begin
            capture_frame(dat, lr, bp, tc);
            checks++;
            if (dat[63:40] !== lv[f] || dat[31:8] !== ~lv[f]) begin
                $display("FAIL bp_order%0d: got %h/%h expected %h/%h", f, dat[63:40], dat[31:8], lv[f], ~lv[f]);
            end else passed++;
        end
    endtask

    task automatic test_underrun();
        logic [63:0] dat;
        logic [63:0] lr;
        logic [3:0]  bp;
        int          tc;
        i_mode = 1'b1;
        do_reset();
        ticks(772);
        checks++;
        if (o_underrun !== 1'b0) $display("FAIL ur_unarmed: got %b expected 0", o_underrun);
        else passed++;
        push_frame(24'hC0FFEE, 24'h123456);
        ticks(255);
        checks++;
        if (o_underrun !== 1'b0 || o_level !== 3'd0) begin
            $display("FAIL ur_after_pop: got underrun %b level %0d expected 0 0", o_underrun, o_level);
        end else passed++;
        capture_frame(dat, lr, bp, tc);
        checks++;
        if (dat !== 64'hC0FFEE00_12345600) $display("FAIL ur_data: got %h expected c0ffee0012345600", dat);
        else passed++;
        checks++;
        if (o_underrun !== 1'b1) $display("FAIL ur_set: got %b expected 1", o_underrun);
        else passed++;
        capture_frame(dat, lr, bp, tc);
        checks++;
        if (dat !== 64'h0) $display("FAIL ur_zero_frame: got %h expected 0", dat);
        else passed++;
        ticks(255);
        i_clr_underrun = 1'b1;
        tick();
        checks++;
        if (o_underrun !== 1'b1 || o_frame_tick !== 1'b1) begin
            $display("FAIL ur_set_wins: got underrun %b tick %b expected 1 1", o_underrun, o_frame_tick);
        end else passed++;
        tick();
        i_clr_underrun = 1'b0;
        checks++;
        if (o_underrun !== 1'b0) $display("FAIL ur_clear: got %b expected 0", o_underrun);
        else passed++;
    endtask

    task automatic test_mute();
        logic [63:0] dat;
        logic [63:0] lr;
        logic [3:0]  bp;
        int          tc;
        i_mode = 1'b1;
        do_reset();
        i_mute = 1'b1;
        push_frame(24'hFFFFFF, 24'hFFFFFF);
        push_frame(24'hAAAAAA, 24'h555555);
        checks++;
        if (o_level !== 3'd2) $display("FAIL mute_level2: got %0d expected 2", o_level);
        else passed++;
        ticks(2);
        checks++;
        if (o_level !== 3'd1 || o_frame_tick !== 1'b1) begin
            $display("FAIL mute_level1: got level %0d tick %b expected 1 1", o_level, o_frame_tick);
        end else passed++;
        capture_frame(dat, lr, bp, tc);
        checks++;
        if (dat !== 64'h0 || tc != 1) $display("FAIL mute_frame1: got %h ticks %0d expected 0 1", dat, tc);
        else passed++;
        checks++;
        if (o_level !== 3'd0 || o_frame_tick !== 1'b1) begin
            $display("FAIL mute_level0: got level %0d tick %b expected 0 1", o_level, o_frame_tick);
        end else passed++;
        capture_frame(dat, lr, bp, tc);
        checks++;
        if (dat !== 64'h0 || tc != 1 || o_frame_tick !== 1'b1) begin
            $display("FAIL mute_frame2: got %h ticks %0d next %b expected 0 1 1", dat, tc, o_frame_tick);
        end else passed++;
        i_mute = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        i_mode = 1'b1;
        do_reset();
        push_frame(24'h000000, 24'h00FFFF);
        push_frame(24'h111111, 24'h222222);
        ticks(164);
        checks++;
        if (o_dacdat !== 1'b1 || o_bclk !== 1'b1 || o_level !== 3'd1) begin
            $display("FAIL mid_pre: got dat %b bclk %b level %0d expected 1 1 1", o_dacdat, o_bclk, o_level);
        end else passed++;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({o_bclk, o_lrclk, o_dacdat, o_underrun} !== 4'b0100 || o_level !== 3'd0) begin
            $display("FAIL mid_reset: got %b level %0d expected 0100 0",
                     {o_bclk, o_lrclk, o_dacdat, o_underrun}, o_level);
        end else passed++;
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (o_frame_tick === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 4) $display("FAIL mid_first_tick: got cycle %0d expected 4", n);
        else passed++;
    endtask

    initial begin
        s_if.valid = 1'b0;
        s_if.left  = '0;
        s_if.right = '0;
        test_reset();
        test_lj();
        test_i2s();
        test_backpressure();
        test_underrun();
        test_mute();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
